dma_prog_port: RTL

CPU-facing slave register port of the DMA controller. It decodes 8237-style programming cycles (CS_N, IOR_N, IOW_N, A3..A0, DB) and holds the per-channel base/current address and word-count registers, plus the mode, command, mask and status registers. It returns read data to the host and applies address/word updates requested by the transfer timing unit. It is the responder end of the programming bus that the host-side initiator drives.

---
 rtl/dma_prog_port_if.sv | 27 ++
 rtl/dma_prog_port.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_prog_port_if.sv
// dma_prog_port_if: host programming bus of the DMA controller.
//   master : host-side initiator (drives strobes, address, write data)
//   slave  : register port (returns read data and its drive enable)
// Signals:
//   CS_N, HLDA, IOR_N, IOW_N : chip select, hold ack, read/write strobes
//   A[3:0], DB_IN[7:0]       : register address, write data
//   DB_OUT[7:0], DB_OE       : read data and tristate enable
interface dma_prog_port_if;
  logic       CS_N;
  logic       HLDA;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;

  modport master (
    output CS_N, HLDA, IOR_N, IOW_N, A, DB_IN,
    input  DB_OUT, DB_OE
  );

  modport slave (
    input  CS_N, HLDA, IOR_N, IOW_N, A, DB_IN,
    output DB_OUT, DB_OE
  );
endinterface

// File: rtl/dma_prog_port.sv
// dma_prog_port: 8237-style CPU programming port of the DMA controller.
// Holds per-channel base/current address and word count, plus mode,
// command, mask and status (TC) registers; applies per-byte advances
// requested by the transfer timing unit.
// Ports:
//   CLK, RESET_N   : clock, asynchronous active-low reset
//   bus (slave)    : programming bus (see dma_prog_port_if)
//   dec_en, dec_ch : one-cycle advance request and its channel
//   cur_addr       : current address of channel dec_ch
//   mode, mask     : mode registers (ch0 in LSBs), mask bits
//   command, tc    : command register, terminal-count pulse
// Build option: DMA_PROG_READBACK_EN enables channel address/word-count
// readback; without it those reads return 0x00 and leave the byte
// pointer unchanged.
module dma_prog_port #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  dma_prog_port_if.slave      bus,
  input  logic                dec_en,
  input  logic [1:0]          dec_ch,
  output logic [15:0]         cur_addr,
  output logic [8*NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0]   mask,
  output logic [7:0]          command,
  output logic                tc
);

  typedef enum logic [3:0] {
    REG_CMD_STAT = 4'h8,
    REG_SMASK    = 4'hA,
    REG_MODE     = 4'hB,
    REG_CLR_FF   = 4'hC,
    REG_MCLR     = 4'hD,
    REG_MASK_ALL = 4'hF
  } reg_e;

  logic [15:0]       base_addr_q [NUM_CH];
  logic [15:0]       base_addr_d [NUM_CH];
  logic [15:0]       cur_addr_q  [NUM_CH];
  logic [15:0]       cur_addr_d  [NUM_CH];
  logic [15:0]       base_wc_q   [NUM_CH];
  logic [15:0]       base_wc_d   [NUM_CH];
  logic [15:0]       cur_wc_q    [NUM_CH];
  logic [15:0]       cur_wc_d    [NUM_CH];
  logic [7:0]        mode_q      [NUM_CH];
  logic [7:0]        mode_d      [NUM_CH];
  logic [7:0]        cmd_q, cmd_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] stat_q, stat_d;
  logic              ff_q, ff_d;
  logic              db_oe_q, db_oe_d;
  logic [7:0]        db_out_q, db_out_d;
  logic              tc_q, tc_d;

  // Strobe level seen on the previous edge; an access needs a high-to-low
  // transition, and reset forces "low" so a held strobe must rise first.
  logic              iow_hi_q, ior_hi_q;

  logic              prog;
  logic              wr_start;
  logic              rd_start;
  logic              mclr;
  logic [1:0]        ch;

  assign prog     = !bus.CS_N && !bus.HLDA;
  assign wr_start = prog && !bus.IOW_N && bus.IOR_N && iow_hi_q;
  assign rd_start = prog && !bus.IOR_N && bus.IOW_N && ior_hi_q;
  assign ch       = bus.A[2:1];

  function automatic logic [15:0] set_byte(input logic [15:0] w,
                                           input logic        hi,
                                           input logic [7:0]  b);
    set_byte = hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  always_comb begin
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_wc_d   = base_wc_q;
    cur_wc_d    = cur_wc_q;
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    mask_d      = mask_q;
    stat_d      = stat_q;
    ff_d        = ff_q;
    db_oe_d     = db_oe_q;
    db_out_d    = db_out_q;
    tc_d        = 1'b0;
    mclr        = 1'b0;

    // Host read; status clear is applied before the TC set below so a
    // coincident terminal count survives.
    if (rd_start) begin
      db_oe_d  = 1'b1;
      db_out_d = '0;
      if (!bus.A[3]) begin
`ifdef DMA_PROG_READBACK_EN
        if (bus.A[0]) begin
          db_out_d = ff_q ? cur_wc_q[ch][15:8] : cur_wc_q[ch][7:0];
        end else begin
          db_out_d = ff_q ? cur_addr_q[ch][15:8] : cur_addr_q[ch][7:0];
        end
        ff_d = ~ff_q;
`endif
      end else if (bus.A == REG_CMD_STAT) begin
        db_out_d = 8'(stat_q);
        stat_d   = '0;
      end
    end else if (db_oe_q && (bus.IOR_N || !prog)) begin
      db_oe_d = 1'b0;
    end

    // Transfer advance.
    if (dec_en) begin
      if (cur_wc_q[dec_ch] == '0) begin
        tc_d           = 1'b1;
        stat_d[dec_ch] = 1'b1;
      end
      if (cur_wc_q[dec_ch] == '0 && mode_q[dec_ch][4]) begin
        cur_addr_d[dec_ch] = base_addr_q[dec_ch];
        cur_wc_d[dec_ch]   = base_wc_q[dec_ch];
      end else begin
        cur_addr_d[dec_ch] = mode_q[dec_ch][5] ? cur_addr_q[dec_ch] - 16'd1
                                               : cur_addr_q[dec_ch] + 16'd1;
        cur_wc_d[dec_ch]   = cur_wc_q[dec_ch] - 16'd1;
      end
    end

    // Host write; built from the _q value so a coincident advance on the
    // same register is discarded rather than merged.
    if (wr_start) begin
      if (!bus.A[3]) begin
        ff_d = ~ff_q;
        if (bus.A[0]) begin
          base_wc_d[ch] = set_byte(base_wc_q[ch], ff_q, bus.DB_IN);
          cur_wc_d[ch]  = set_byte(cur_wc_q[ch],  ff_q, bus.DB_IN);
        end else begin
          base_addr_d[ch] = set_byte(base_addr_q[ch], ff_q, bus.DB_IN);
          cur_addr_d[ch]  = set_byte(cur_addr_q[ch],  ff_q, bus.DB_IN);
        end
      end else begin
        case (bus.A)
          REG_CMD_STAT: cmd_d                   = bus.DB_IN;
          REG_SMASK:    mask_d[bus.DB_IN[1:0]]  = bus.DB_IN[2];
          REG_MODE:     mode_d[bus.DB_IN[1:0]]  = bus.DB_IN;
          REG_CLR_FF:   ff_d                    = 1'b0;
          REG_MCLR:     mclr                    = 1'b1;
          REG_MASK_ALL: mask_d                  = bus.DB_IN[NUM_CH-1:0];
          default:      ;
        endcase
      end
    end

    // Master clear overrides everything computed above.
    if (mclr) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        base_addr_d[i] = '0;
        cur_addr_d[i]  = '0;
        base_wc_d[i]   = '0;
        cur_wc_d[i]    = '0;
        mode_d[i]      = '0;
      end
      cmd_d    = '0;
      mask_d   = '1;
      stat_d   = '0;
      ff_d     = 1'b0;
      db_oe_d  = 1'b0;
      db_out_d = '0;
      tc_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_wc_q[i]   <= '0;
        cur_wc_q[i]    <= '0;
        mode_q[i]      <= '0;
      end
      cmd_q    <= '0;
      mask_q   <= '1;
      stat_q   <= '0;
      ff_q     <= 1'b0;
      db_oe_q  <= 1'b0;
      db_out_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_wc_q   <= base_wc_d;
      cur_wc_q    <= cur_wc_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      mask_q      <= mask_d;
      stat_q      <= stat_d;
      ff_q        <= ff_d;
      db_oe_q     <= db_oe_d;
      db_out_q    <= db_out_d;
      tc_q        <= tc_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      iow_hi_q <= 1'b0;
      ior_hi_q <= 1'b0;
    end else begin
      iow_hi_q <= bus.IOW_N;
      ior_hi_q <= bus.IOR_N;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mode
    assign mode[8*g +: 8] = mode_q[g];
  end

  assign cur_addr   = cur_addr_q[dec_ch];
  assign mask       = mask_q;
  assign command    = cmd_q;
  assign tc         = tc_q;
  assign bus.DB_OUT = db_out_q;
  assign bus.DB_OE  = db_oe_q;

endmodule
